// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of one synchronous memory.
// Define MEM_ARB_FIXED_PRI_EN for fixed priority (port 0 wins ties); the default is round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

  state_t            state_reg;
  logic              owner_reg;
  logic              we_reg;
  logic [CNT_W-1:0]  cnt_reg;
`ifndef MEM_ARB_FIXED_PRI_EN
  logic              last_reg;
`endif

  logic              pick_next;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // pick_next: 0 selects port 0, 1 selects port 1 (only meaningful when a req is up)
  always_comb begin
`ifdef MEM_ARB_FIXED_PRI_EN
    pick_next = ~req0;
`else
    pick_next = (req0 && req1) ? ~last_reg : ~req0;
`endif
    sel_we    = pick_next ? we1    : we0;
    sel_addr  = pick_next ? addr1  : addr0;
    sel_wdata = pick_next ? wdata1 : wdata0;
  end

  // Outputs of each state are registered on the edge that enters it, so
  // gnt/strobes are visible exactly while the FSM sits in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_reg  <= 1'b1;
`endif
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            state_reg <= ACCESS;
            owner_reg <= pick_next;
            we_reg    <= sel_we;
`ifndef MEM_ARB_FIXED_PRI_EN
            last_reg  <= pick_next;
`endif
            busy      <= 1'b1;
            gnt0      <= ~pick_next;
            gnt1      <= pick_next;
            mem_write <= sel_we;
            mem_read  <= ~sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg <= RWAIT;
            cnt_reg   <= CNT_W'(RD_LAT - 1);
          end
        end
        RWAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            if (owner_reg) begin
              rdata1  <= mem_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_rdata;
              rvalid0 <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, grant-order scoreboard,
// directed latency checks plus randomized contention/fill traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy, mem_read, mem_write;
  logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural synchronous memory with RD_LAT-deep read pipeline
  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem_read ? mem[mem_addr] : pipe[0];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  typedef struct packed { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } op_t;
  typedef struct packed { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } exp_t;
  typedef struct { int port; int cyc; op_t op; } glog_t;
  typedef struct { int port; int cyc; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] got; logic [DATA_W-1:0] exp; bit orphan; } rlog_t;

  op_t   q0[$], q1[$];
  exp_t  e0[$], e1[$];
  glog_t glog[$];
  rlog_t rlog[$];
  logic [DATA_W-1:0] model_mem [32];
  int n_checks = 0, n_fail = 0;
  int overlap_cnt = 0, strobe_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read && mem_write) overlap_cnt++;
      if ((mem_read || mem_write) != (gnt0 || gnt1)) strobe_err++;
      if (gnt0 && gnt1) strobe_err++;
    end
  end

  function automatic op_t mk_op(input logic we, input int a, input int d);
    op_t o;
    o.we = we; o.addr = ADDR_W'(a); o.data = DATA_W'(d);
    return o;
  endfunction

  task automatic present(input int p, input op_t op);
    if (p == 0) begin req0 = 1'b1; we0 = op.we; addr0 = op.addr; wdata0 = op.data; end
    else        begin req1 = 1'b1; we1 = op.we; addr1 = op.addr; wdata1 = op.data; end
  endtask

  task automatic note_grant(input int p, input int cyc, input op_t op);
    glog_t g; exp_t e;
    g.port = p; g.cyc = cyc; g.op = op;
    glog.push_back(g);
    if (op.we) model_mem[op.addr] = op.data;
    else begin
      e.addr = op.addr; e.data = model_mem[op.addr];
      if (p == 0) e0.push_back(e); else e1.push_back(e);
    end
    $display("[%0t] grant port%0d %s addr=%0d wdata=%02h", $time, p, op.we ? "write" : "read ", op.addr, op.data);
  endtask

  task automatic note_rvalid(input int p, input int cyc, input logic [DATA_W-1:0] got);
    rlog_t r; exp_t e;
    r.port = p; r.cyc = cyc; r.got = got; r.orphan = 1'b0; r.addr = '0; r.exp = '0;
    if (p == 0 && e0.size() > 0) begin e = e0.pop_front(); r.addr = e.addr; r.exp = e.data; end
    else if (p == 1 && e1.size() > 0) begin e = e1.pop_front(); r.addr = e.addr; r.exp = e.data; end
    else r.orphan = 1'b1;
    rlog.push_back(r);
    $display("[%0t] rvalid port%0d addr=%0d rdata=%02h", $time, p, r.addr, got);
  endtask

  // Drives queued ops on both ports, holding req across grants; records grants/read data
  task automatic run_ops(input int budget, output bit to);
    op_t cur0, cur1;
    int cyc = 0;
    cur0 = '0; cur1 = '0; to = 1'b0;
    glog.delete(); rlog.delete();
    if (q0.size() > 0) begin cur0 = q0.pop_front(); present(0, cur0); end
    if (q1.size() > 0) begin cur1 = q1.pop_front(); present(1, cur1); end
    while (req0 || req1 || e0.size() > 0 || e1.size() > 0) begin
      if (cyc >= budget) begin to = 1'b1; break; end
      @(negedge clk); cyc++;
      if (rvalid0) note_rvalid(0, cyc, rdata0);
      if (rvalid1) note_rvalid(1, cyc, rdata1);
      if (gnt0) begin
        note_grant(0, cyc, cur0);
        if (q0.size() > 0) begin cur0 = q0.pop_front(); present(0, cur0); end else req0 = 1'b0;
      end
      if (gnt1) begin
        note_grant(1, cyc, cur1);
        if (q1.size() > 0) begin cur1 = q1.pop_front(); present(1, cur1); end else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {gnt0, gnt1, rvalid0, rvalid1}); end
    n_checks++; if ({busy, mem_read, mem_write} !== 3'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000", {busy, mem_read, mem_write}); end
    n_checks++; if ({rdata0, rdata1, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {rdata0, rdata1, mem_addr, mem_wdata}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_write();
    present(0, mk_op(1'b1, 5, 8'h41));
    @(negedge clk);
    n_checks++; if ({gnt0, gnt1, mem_write, mem_read, busy} !== 5'b10101) begin n_fail++; $display("FAIL wr_ctl: got %b expected 10101", {gnt0, gnt1, mem_write, mem_read, busy}); end
    n_checks++; if (mem_addr !== 5'd5) begin n_fail++; $display("FAIL wr_addr: got %0d expected 5", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h41) begin n_fail++; $display("FAIL wr_data: got %h expected 41", mem_wdata); end
    req0 = 1'b0; model_mem[5] = 8'h41;
    $display("[%0t] grant port0 write addr=5 wdata=41", $time);
    @(negedge clk);
    n_checks++; if ({gnt0, mem_write, busy} !== 3'b000) begin n_fail++; $display("FAIL wr_done: got %b expected 000", {gnt0, mem_write, busy}); end
    n_checks++; if (mem_addr !== 5'd5) begin n_fail++; $display("FAIL wr_addr_hold: got %0d expected 5", mem_addr); end
  endtask

  task automatic test_read_back();
    present(1, mk_op(1'b0, 5, 0));
    @(negedge clk);
    n_checks++; if ({gnt1, gnt0, mem_read, mem_write} !== 4'b1010) begin n_fail++; $display("FAIL rd_ctl: got %b expected 1010", {gnt1, gnt0, mem_read, mem_write}); end
    n_checks++; if (mem_addr !== 5'd5) begin n_fail++; $display("FAIL rd_addr: got %0d expected 5", mem_addr); end
    req1 = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      @(negedge clk);
      n_checks++; if ({rvalid1, busy} !== 2'b01) begin n_fail++; $display("FAIL rd_wait: got %b expected 01", {rvalid1, busy}); end
    end
    @(negedge clk);
    n_checks++; if ({rvalid1, rvalid0, busy} !== 3'b100) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 100", {rvalid1, rvalid0, busy}); end
    n_checks++; if (rdata1 !== 8'h41) begin n_fail++; $display("FAIL rd_data: got %h expected 41", rdata1); end
    $display("[%0t] rvalid port1 addr=5 rdata=%02h", $time, rdata1);
    @(negedge clk);
    n_checks++; if ({rvalid1, rdata1} !== {1'b0, 8'h41}) begin n_fail++; $display("FAIL rd_hold: got %b/%h expected 0/41", rvalid1, rdata1); end
  endtask

  task automatic test_reset_mid_read();
    int k; int late;
    present(0, mk_op(1'b0, 5, 0));
    k = 0; do begin @(negedge clk); k++; end while (!gnt0 && k < 8);
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL mrst_gnt_a: got %b expected 1 within 8 cycles", gnt0); end
    req0 = 1'b0;
    k = 0; do begin @(negedge clk); k++; end while (!rvalid0 && k < 8);
    n_checks++; if (rdata0 !== model_mem[5]) begin n_fail++; $display("FAIL mrst_pre_data: got %h expected %h", rdata0, model_mem[5]); end
    present(0, mk_op(1'b0, 5, 0));
    k = 0; do begin @(negedge clk); k++; end while (!gnt0 && k < 8);
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL mrst_gnt_b: got %b expected 1", mem_read); end
    req0 = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if ({gnt0, mem_read, busy, rvalid0} !== 4'b0) begin n_fail++; $display("FAIL mrst_ctl: got %b expected 0000", {gnt0, mem_read, busy, rvalid0}); end
    n_checks++; if ({rdata0, mem_addr} !== '0) begin n_fail++; $display("FAIL mrst_data: got %h expected 0", {rdata0, mem_addr}); end
    @(negedge clk); rst = 1'b0;
    late = 0;
    repeat (4 + RD_LAT) begin
      @(negedge clk);
      if (rvalid0 || rvalid1 || gnt0 || gnt1 || busy || mem_read) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL mrst_after: got %0d active cycles expected 0", late); end
    n_checks++; if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL mrst_rdata: got %h expected 00", rdata0); end
  endtask

  task automatic test_contention();
    bit to; int expp;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk_op(1'b1, $urandom_range(0, 31), $urandom_range(0, 255)));
      q1.push_back(mk_op(1'b1, $urandom_range(0, 31), $urandom_range(0, 255)));
    end
    run_ops(200, to);
    n_checks++; if (to !== 1'b0 || glog.size() != 16) begin n_fail++; $display("FAIL cont_count: got %0d grants (timeout %0b) expected 16", glog.size(), to); end
    for (int i = 0; i < glog.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
      expp = (i < 8) ? 0 : 1;
`else
      expp = i % 2;
`endif
      n_checks++; if (glog[i].port != expp) begin n_fail++; $display("FAIL cont_order[%0d]: got port%0d expected port%0d", i, glog[i].port, expp); end
      if (i > 0) begin
        n_checks++; if (glog[i].cyc - glog[i-1].cyc != 2) begin n_fail++; $display("FAIL cont_gap[%0d]: got %0d expected 2", i, glog[i].cyc - glog[i-1].cyc); end
      end
    end
  endtask

  task automatic test_fill();
    bit to;
    for (int a = 0; a < 32; a++) q0.push_back(mk_op(1'b1, a, a));
    for (int i = 0; i < 16; i++) q1.push_back(mk_op(1'b1, 2 * $urandom_range(0, 15) + 1, $urandom_range(8'h20, 8'h7E)));
    run_ops(400, to);
    n_checks++; if (to !== 1'b0 || glog.size() != 48) begin n_fail++; $display("FAIL fill_wr_count: got %0d grants (timeout %0b) expected 48", glog.size(), to); end
    for (int a = 0; a < 16; a++) q0.push_back(mk_op(1'b0, a, 0));
    for (int a = 16; a < 32; a++) q1.push_back(mk_op(1'b0, a, 0));
    run_ops(400, to);
    n_checks++; if (to !== 1'b0 || rlog.size() != 32) begin n_fail++; $display("FAIL fill_rd_count: got %0d rvalids (timeout %0b) expected 32", rlog.size(), to); end
    foreach (rlog[i]) begin
      n_checks++; if (rlog[i].orphan || rlog[i].got !== rlog[i].exp) begin n_fail++; $display("FAIL fill_data addr %0d: got %h expected %h (orphan %0b)", rlog[i].addr, rlog[i].got, rlog[i].exp, rlog[i].orphan); end
      if (!rlog[i].addr[0]) begin
        n_checks++; if (rlog[i].got !== DATA_W'(rlog[i].addr)) begin n_fail++; $display("FAIL fill_even addr %0d: got %h expected %h", rlog[i].addr, rlog[i].got, DATA_W'(rlog[i].addr)); end
      end
    end
    n_checks++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt); end
    n_checks++; if (strobe_err != 0) begin n_fail++; $display("FAIL strobe_vs_gnt: got %0d cycles expected 0", strobe_err); end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int a = 0; a < 4; a++) q0.push_back(mk_op(1'b0, a, 0));
    run_ops(100, to);
    n_checks++; if (to !== 1'b0 || glog.size() != 4 || rlog.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d grants %0d rvalids (timeout %0b) expected 4/4", glog.size(), rlog.size(), to); end
    for (int i = 0; i < glog.size() && i < rlog.size(); i++) begin
      if (i > 0) begin
        n_checks++; if (glog[i].cyc - glog[i-1].cyc != 2 + RD_LAT) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, glog[i].cyc - glog[i-1].cyc, 2 + RD_LAT); end
      end
      n_checks++; if (rlog[i].cyc - glog[i].cyc != 1 + RD_LAT) begin n_fail++; $display("FAIL b2b_lat[%0d]: got %0d expected %0d", i, rlog[i].cyc - glog[i].cyc, 1 + RD_LAT); end
      n_checks++; if (rlog[i].orphan || rlog[i].addr != ADDR_W'(i) || rlog[i].got !== rlog[i].exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got addr %0d data %h expected addr %0d data %h", i, rlog[i].addr, rlog[i].got, i, rlog[i].exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_reset_mid_read();
    test_contention();
    test_fill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
